// File: rtl/pong_pkg.sv
// Shared pong definitions: collision bit indices, ball geometry and active video size.
package pong_pkg;

   localparam int COLL_X1 = 0;
   localparam int COLL_X2 = 1;
   localparam int COLL_Y1 = 2;
   localparam int COLL_Y2 = 3;

   localparam int BALL_SIZE = 8;
   localparam int H_ACTIVE  = 640;
   localparam int V_ACTIVE  = 480;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
   } point_t;

   // Raster coordinates wrap modulo 1024; a wrapped point that is never scanned never hits.
   function automatic point_t probe_point(input logic [9:0] base_x, input logic [9:0] base_y,
                                          input logic [9:0] off_x, input logic [9:0] off_y);
      point_t p;
      p.x = base_x + off_x;
      p.y = base_y + off_y;
      return p;
   endfunction

endpackage

// File: rtl/frame_tick.sv
// One-cycle tick per frame: registered compare of the raster position against a mark,
// followed by a rising-edge detect so any clk-to-pixel ratio yields a single tick.
module frame_tick #(
   parameter int V_MARK = 480,
   parameter int H_MARK = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] h_cnt,
   input  logic [9:0] v_cnt,
   output logic       tick
);

   logic cmp;
   logic cmp_q;
   logic cmp_q2;

   assign cmp = (v_cnt == 10'(V_MARK)) && (h_cnt == 10'(H_MARK));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cmp_q  <= 1'b0;
         cmp_q2 <= 1'b0;
      end else begin
         cmp_q  <= cmp;
         cmp_q2 <= cmp_q;
      end
   end

   assign tick = cmp_q & ~cmp_q2;

endmodule

// File: rtl/collision_probe.sv
// Per-frame ball collision detector: samples the bouncing-object flag at four probe points
// around the ball, publishes {Y2,Y1,X2,X1} once per frame. Optional axis holdoff: COLLISION_HOLDOFF_EN.
module collision_probe #(
   parameter int BALL_SIZE      = pong_pkg::BALL_SIZE,
   parameter int FRAME_V        = pong_pkg::V_ACTIVE,
   parameter int HOLDOFF_FRAMES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] h_cnt,
   input  logic [9:0] v_cnt,
   input  logic       obj,
   input  logic [9:0] ball_x,
   input  logic [9:0] ball_y,
   input  logic       enable,
   output logic [3:0] coll,
   output logic       coll_valid
);

   import pong_pkg::*;

   localparam logic [9:0] SIZE_W = 10'(BALL_SIZE);
   localparam logic [9:0] HALF_W = 10'(BALL_SIZE / 2);

   logic [9:0] px;
   logic [9:0] py;
   logic [3:0] acc;
   logic [3:0] hits;
   logic [3:0] raw;
   logic [3:0] pub;
   logic       tick;
   point_t     probe [4];

   frame_tick #(
      .V_MARK (FRAME_V),
      .H_MARK (0)
   ) u_frame_tick (
      .clk   (clk),
      .rst   (rst),
      .h_cnt (h_cnt),
      .v_cnt (v_cnt),
      .tick  (tick)
   );

   always_comb begin
      probe[COLL_X1] = probe_point(px, py, 10'd0,  HALF_W);
      probe[COLL_X2] = probe_point(px, py, SIZE_W, HALF_W);
      probe[COLL_Y1] = probe_point(px, py, HALF_W, 10'd0);
      probe[COLL_Y2] = probe_point(px, py, HALF_W, SIZE_W);
   end

   always_comb begin
      hits = '0;
      for (int i = 0; i < 4; i++) begin
         hits[i] = enable && obj && (h_cnt == probe[i].x) && (v_cnt == probe[i].y);
      end
   end

   // A hit landing in the tick cycle belongs to the frame being closed.
   assign raw = acc | hits;

`ifdef COLLISION_HOLDOFF_EN
   localparam int CNT_W = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;

   logic [CNT_W-1:0] x_hold;
   logic [CNT_W-1:0] y_hold;

   always_comb begin
      pub = raw;
      if (x_hold != '0) begin
         pub[COLL_X1] = 1'b0;
         pub[COLL_X2] = 1'b0;
      end
      if (y_hold != '0) begin
         pub[COLL_Y1] = 1'b0;
         pub[COLL_Y2] = 1'b0;
      end
   end

   // Suppress an axis for a few frames after it reports, so a ball still overlapping
   // the object does not bounce twice.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_hold <= '0;
         y_hold <= '0;
      end else if (tick) begin
         if (x_hold != '0) begin
            x_hold <= x_hold - CNT_W'(1);
         end else if (raw[COLL_X1] || raw[COLL_X2]) begin
            x_hold <= CNT_W'(HOLDOFF_FRAMES);
         end
         if (y_hold != '0) begin
            y_hold <= y_hold - CNT_W'(1);
         end else if (raw[COLL_Y1] || raw[COLL_Y2]) begin
            y_hold <= CNT_W'(HOLDOFF_FRAMES);
         end
      end
   end
`else
   assign pub = raw;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         coll       <= '0;
         coll_valid <= 1'b0;
         acc        <= '0;
         px         <= '0;
         py         <= '0;
      end else begin
         coll_valid <= tick;
         if (tick) begin
            coll <= pub;
            acc  <= '0;
            px   <= ball_x;
            py   <= ball_y;
         end else if (enable) begin
            acc <= raw;
         end else begin
            acc <= '0;
         end
      end
   end

endmodule

// File: doc/collision_probe.md
# collision_probe

Per-frame collision detector between the VGA scan and the ball physics. It samples the pixel generator's "bouncing object" flag at four probe points around the ball as the raster passes them. Hits are accumulated over one video frame and published as a registered 4-bit collision vector with a one-cycle strobe at the frame boundary. The vector replaces the combinational probe compares that currently feed `Ball` directly.

## Interface

Parameters:
- `BALL_SIZE`, default 8: ball edge length in pixels; the probe offsets derive from it.
- `FRAME_V`, default 480: `v_cnt` value that marks the frame boundary.
- `HOLDOFF_FRAMES`, default 2: number of frames an axis is suppressed after a reported hit. Used only when `COLLISION_HOLDOFF_EN` is defined.

Ports:
- `clk`, in, 1: system clock. This is the single clock domain.
- `rst`, in, 1: **asynchronous, active-low** reset.
- `h_cnt`, in, 10: horizontal raster counter from `vga_controller`.
- `v_cnt`, in, 10: vertical raster counter from `vga_controller`.
- `obj`, in, 1: pixel at (`h_cnt`,`v_cnt`) belongs to a border or paddle. This is `BouncingObject` from `pixel_gen`.
- `ball_x`, in, 10: ball top-left X.
- `ball_y`, in, 10: ball top-left Y.
- `enable`, in, 1: game is in the play state. When low, no hits are recorded.
- `coll`, out, 4: collision vector {Y2,Y1,X2,X1} for the last completed frame.
- `coll_valid`, out, 1: one-cycle strobe marking a new `coll` value.

## Operation

- Probe snapshot:
  - `px` and `py` are registers loaded from `ball_x` and `ball_y` on each frame tick.
  - The probe points stay fixed for the whole frame.
- Probe points use half = `BALL_SIZE/2`:
  - X1 = (px, py+half)
  - X2 = (px+BALL_SIZE, py+half)
  - Y1 = (px+half, py)
  - Y2 = (px+half, py+BALL_SIZE)
- Probe arithmetic:
  - All sums are 10-bit and wrap modulo 1024. No saturation.
  - A wrapped point that never occurs in the scan simply never hits.
- Accumulator:
  - `acc[3:0]` is a sticky register.
  - On each clk, `acc[i]` is set when `enable && obj && h_cnt==probe_i.x && v_cnt==probe_i.y`.
  - Multiple clk cycles per pixel are harmless because the bits are sticky.
- Frame tick:
  - `cmp = (v_cnt==FRAME_V && h_cnt==0)` is registered into `cmp_q`, then `cmp_q` into `cmp_q2`.
  - tick = `cmp_q & ~cmp_q2`.
  - This yields exactly one tick per frame, regardless of the clk-to-pixel ratio.
- On tick:
  - `coll` ← `acc | hits_this_cycle`.
  - `acc` ← 0.
  - px/py are re-snapshotted.
  - `coll_valid` pulses high.
- `enable` low:
  - `acc` is held at 0.
  - Ticks still occur and publish `coll`=0 with `coll_valid` pulsing.
- Reset (asserted at any time):
  - `coll`=0, `coll_valid`=0, `acc`=0, px=py=0, `cmp_q`=`cmp_q2`=0, holdoff counters=0.
  - A reset mid-frame discards partial hits.

## Timing

- Counters reach (FRAME_V, 0) before clk edge N. `cmp_q` rises at edge N.
- `coll` and `coll_valid` update at edge N+1. Latency is 2 clk from the boundary.
- `coll_valid` is high for exactly one clk cycle.
- `coll` holds its value until the next tick.
- A hit in the same cycle as the tick is included in the published vector and is not carried into the next frame.
- `acc` takes effect one cycle after the qualifying sample.

## Configuration

- `COLLISION_HOLDOFF_EN` defined:
  - There are two counters, one for the X axis and one for the Y axis, each ⌈log2(HOLDOFF_FRAMES+1)⌉ bits wide.
  - When a published vector has a nonzero X pair, the X counter loads `HOLDOFF_FRAMES`.
  - While the X counter is nonzero, the X bits of the next published vectors are forced to 0, and the counter decrements by one per tick.
  - The Y axis behaves the same way.
  - This prevents double bounces while the ball is still overlapping the object.
- `COLLISION_HOLDOFF_EN` undefined:
  - No counters exist.
  - `coll` is the raw per-frame vector.
  - `HOLDOFF_FRAMES` is ignored.

## Structure

- Shared package `pong_pkg` holds:
  - collision bit indices `COLL_X1=0`, `COLL_X2=1`, `COLL_Y1=2`, `COLL_Y2=3`
  - `BALL_SIZE`
  - `H_ACTIVE=640`
  - `V_ACTIVE=480`
- One sub-module, `frame_tick`, contains the registered compare and rising-edge detect and outputs `tick`. It is reusable by the score and game logic.
- Probe compare, accumulator and holdoff stay in `collision_probe`.

## Test plan

- Reset deasserted with no `obj` over two frames → two `coll_valid` pulses, each 2 clk after (480,0), `coll`=0000.
- Ball snapshot (100,200), `obj` asserted only at (100,204) in frame k → at the tick of frame k, `coll`=0001. Next frame with no hits → `coll`=0000.
- `obj` at (104,200) and (104,208) in the same frame → `coll`=1100. `acc` is cleared afterwards.
- Hit at (100,204) asserted in the exact tick cycle → included in that frame's `coll`. The next frame reports 0000.
- `enable`=0 with hits present → `coll`=0000 and `coll_valid` still pulses.
- Reset pulsed mid-frame after a hit → outputs are 0 immediately and the next tick reports 0000.
- `COLLISION_HOLDOFF_EN` with `HOLDOFF_FRAMES`=2 and an X1 hit present in frames 1–4:
  - reported X bits are 01, 00, 00, 01
  - a Y2 hit in frame 2 is still reported as 1000.
